// File: rtl/sp_xmit_ctrl_pkg.sv
// sp_xmit_ctrl_pkg: shared spectrum-path constants and transmit FSM encoding
package sp_xmit_ctrl_pkg;
    localparam int SP_FIFO_WORDS    = 16384;
    localparam int SP_SAMPLE_W      = 16;
    localparam int SP_BYTES_PER_PKT = 1024;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SEND = 2'd2, FIN = 2'd3} sp_xmit_state_t;
endpackage

// File: rtl/sp_xmit_ctrl.sv
// sp_xmit_ctrl: drains SP FIFO samples as fixed-size packets, MSB byte first,
// over a req/ack plus byte-strobe handshake to the Ethernet transmit arbiter
module sp_xmit_ctrl
    import sp_xmit_ctrl_pkg::*;
#(
    parameter int BYTES_PER_PKT = SP_BYTES_PER_PKT,
    parameter int SEQ_W         = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   have_sp_data,
    input  logic                   sp_fifo_rdempty,
    input  logic [SP_SAMPLE_W-1:0] sp_fifo_rddata,
    output logic                   sp_fifo_rdreq,
    output logic                   tx_req,
    input  logic                   tx_ack,
    input  logic                   tx_rd,
    output logic [7:0]             tx_data,
    output logic                   tx_done,
    output logic [SEQ_W-1:0]       sp_seq,
    output logic                   underflow
);
    localparam int CNT_W = $clog2(BYTES_PER_PKT);

    sp_xmit_state_t   state, state_nx;
    logic [CNT_W-1:0] byte_cnt, cnt_nx;
    logic [7:0]       lo_byte, lo_nx, tx_data_nx;
    logic [SEQ_W-1:0] seq_nx;
    logic             byte_sel, sel_nx, empty_word, empty_nx;
    logic             tx_req_nx, tx_done_nx, uf_nx, last;

    assign last = byte_cnt == CNT_W'(BYTES_PER_PKT - 1);
    // pop as the low byte goes out; its value was already captured at the high-byte fetch
    assign sp_fifo_rdreq = (state == SEND) && tx_rd && byte_sel && !empty_word;

    always_comb begin
        state_nx   = state;
        cnt_nx     = byte_cnt;
        sel_nx     = byte_sel;
        lo_nx      = lo_byte;
        empty_nx   = empty_word;
        tx_req_nx  = tx_req;
        tx_data_nx = tx_data;
        tx_done_nx = 1'b0;
        seq_nx     = sp_seq;
        uf_nx      = underflow;
        case (state)
            IDLE: if (have_sp_data && !sp_fifo_rdempty) begin
                state_nx   = REQ;
                tx_req_nx  = 1'b1;
                tx_data_nx = sp_fifo_rddata[15:8];
                lo_nx      = sp_fifo_rddata[7:0];
                sel_nx     = 1'b1;
                cnt_nx     = '0;
                empty_nx   = 1'b0;
            end
            REQ: state_nx = tx_ack ? SEND : REQ;
            SEND: if (tx_rd) begin
                cnt_nx = byte_cnt + CNT_W'(1);
                if (last) begin
                    state_nx   = FIN;
                    tx_req_nx  = 1'b0;
                    tx_done_nx = 1'b1;
                end else if (byte_sel) begin
                    tx_data_nx = lo_byte;
                    sel_nx     = 1'b0;
                end else begin
                    // an empty FIFO yields a zero word and no pop; the packet keeps its length
                    tx_data_nx = sp_fifo_rdempty ? 8'h00 : sp_fifo_rddata[15:8];
                    lo_nx      = sp_fifo_rdempty ? 8'h00 : sp_fifo_rddata[7:0];
                    sel_nx     = 1'b1;
                    empty_nx   = sp_fifo_rdempty;
                    uf_nx      = underflow | sp_fifo_rdempty;
                end
            end
            FIN: begin
                state_nx = IDLE;
                seq_nx   = sp_seq + SEQ_W'(1);
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            byte_sel   <= 1'b0;
            lo_byte    <= '0;
            empty_word <= 1'b0;
            tx_req     <= 1'b0;
            tx_data    <= '0;
            tx_done    <= 1'b0;
            sp_seq     <= '0;
            underflow  <= 1'b0;
        end else begin
            state      <= state_nx;
            byte_cnt   <= cnt_nx;
            byte_sel   <= sel_nx;
            lo_byte    <= lo_nx;
            empty_word <= empty_nx;
            tx_req     <= tx_req_nx;
            tx_data    <= tx_data_nx;
            tx_done    <= tx_done_nx;
            sp_seq     <= seq_nx;
            underflow  <= uf_nx;
        end
    end
endmodule

// File: tb/tb_sp_xmit_ctrl.sv
// tb_sp_xmit_ctrl: randomized scoreboard bench; a word-level FIFO model predicts each packet's bytes
module tb_sp_xmit_ctrl;
    import sp_xmit_ctrl_pkg::*;
    localparam int N     = SP_BYTES_PER_PKT;
    localparam int SEQ_W = 32;

    logic             clk = 0, reset = 1, have_sp_data = 0, sp_fifo_rdempty = 1, sp_fifo_rdreq;
    logic [15:0]      sp_fifo_rddata = 0;
    logic             tx_req, tx_ack = 0, tx_rd = 0, tx_done, underflow;
    logic [7:0]       tx_data;
    logic [SEQ_W-1:0] sp_seq;

    logic [15:0] fifo_q[$], ref_q[$];
    logic [7:0]  exp_q[$];
    int          tests = 0, fails = 0;
    int          pops, exp_pops, done_cnt, starts, consumed, rd_pct, ack_delay, req_age;
    logic [31:0] exp_seq, seq_start;
    bit          exp_uf, granted, exp_done, held, pend, req_seen;

    sp_xmit_ctrl #(.BYTES_PER_PKT(N), .SEQ_W(SEQ_W)) dut (
        .clk(clk), .reset(reset), .have_sp_data(have_sp_data),
        .sp_fifo_rdempty(sp_fifo_rdempty), .sp_fifo_rddata(sp_fifo_rddata),
        .sp_fifo_rdreq(sp_fifo_rdreq), .tx_req(tx_req), .tx_ack(tx_ack), .tx_rd(tx_rd),
        .tx_data(tx_data), .tx_done(tx_done), .sp_seq(sp_seq), .underflow(underflow)
    );

    initial forever #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void refresh();
        sp_fifo_rdempty = fifo_q.size() == 0;
        sp_fifo_rddata  = fifo_q.size() != 0 ? fifo_q[0] : 16'h0;
    endfunction

    task automatic load(int n, bit inc);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = inc ? 16'(i) : 16'($urandom);
            fifo_q.push_back(w);
            ref_q.push_back(w);
        end
        refresh();
    endtask

    // a packet carries the next N/2 stored samples, missing ones sent as zero
    function automatic void build_pkt();
        logic [15:0] w;
        for (int i = 0; i < N / 2; i++) begin
            if (ref_q.size() != 0) begin
                w = ref_q.pop_front();
                exp_pops++;
            end else begin
                w = 16'h0;
                exp_uf = 1;
            end
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        pend = sp_fifo_rdreq;
        @(posedge clk);
        #1;
        if (pend) begin
            pops++;
            if (fifo_q.size() != 0) fifo_q.delete(0);
        end
        refresh();
        if (tx_req && !req_seen) begin
            chk("seq_start", sp_seq, exp_seq);
            seq_start = exp_seq;
            exp_seq++;
            starts++;
            req_age = 0;
            build_pkt();
        end else req_age++;
        req_seen = tx_req;
        tx_ack = tx_req ? (req_age >= ack_delay) : 1'($urandom_range(1));
        tx_rd  = $urandom_range(99) < rd_pct;
    endtask

    task automatic do_reset();
        #2 reset = 1;
        #1;
        chk("rst_req", 32'(tx_req), 0);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_done", 32'(tx_done), 0);
        chk("rst_pop", 32'(sp_fifo_rdreq), 0);
        chk("rst_seq", sp_seq, 0);
        chk("rst_uf", 32'(underflow), 0);
        fifo_q.delete();
        ref_q.delete();
        exp_q.delete();
        exp_seq = 0; exp_uf = 0; pops = 0; exp_pops = 0; starts = 0; req_seen = 0;
        have_sp_data = 0; tx_rd = 0; tx_ack = 0;
        refresh();
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic run_pkts(int n, int budget);
        int d0;
        d0 = done_cnt;
        for (int c = 0; c < budget && done_cnt - d0 < n; c++) tick();
        chk("pkts_done", 32'(done_cnt - d0), 32'(n));
    endtask

    task automatic wait_bytes(int k, int budget);
        for (int c = 0; c < budget && consumed < k; c++) tick();
        chk("reach_byte", 32'(consumed >= k), 1);
    endtask

    task automatic settle(int seq, bit uf, int left);
        repeat (8) tick();
        chk("seq_end", sp_seq, 32'(seq));
        chk("starts", 32'(starts), 32'(seq));
        chk("uf_end", 32'(underflow), 32'(uf));
        chk("pops", 32'(pops), 32'(exp_pops));
        chk("fifo_left", 32'(fifo_q.size()), 32'(left));
        chk("idle_req", 32'(tx_req), 0);
    endtask

    always @(negedge clk) begin
        logic [7:0] b;
        if (reset) begin
            granted = 0; exp_done = 0; consumed = 0;
        end else begin
            chk("tx_done", 32'(tx_done), 32'(exp_done));
            if (exp_done) begin
                chk("req_low_fin", 32'(tx_req), 0);
                chk("seq_hold", sp_seq, seq_start);
                chk("underflow", 32'(underflow), 32'(exp_uf));
                chk("bytes_left", 32'(exp_q.size()), 0);
                chk("req_held", 32'(held), 1);
                done_cnt++;
                consumed = 0;
                exp_done = 0;
            end
            if (granted) begin
                if (!tx_req) held = 0;
                if (tx_rd) begin
                    b = exp_q.size() != 0 ? exp_q.pop_front() : 8'h00;
                    chk("tx_data", 32'(tx_data), 32'(b));
                    consumed++;
                    if (consumed == N) begin
                        granted = 0;
                        exp_done = 1;
                    end
                end
            end else begin
                chk("no_pop_idle", 32'(sp_fifo_rdreq), 0);
                if (tx_req && tx_ack) begin
                    granted = 1; held = 1; consumed = 0;
                end
            end
        end
    end

    initial begin
        rd_pct = 100; ack_delay = 0;
        @(posedge clk);
        #1;
        do_reset(); load(512, 1); have_sp_data = 1;
        run_pkts(1, 3000); settle(1, 0, 0);
        do_reset(); load(SP_FIFO_WORDS, 1); have_sp_data = 1;
        run_pkts(32, 40000); settle(32, 0, 0);
        do_reset(); load(512, 1); rd_pct = 50; ack_delay = 10; have_sp_data = 1;
        run_pkts(1, 6000); settle(1, 0, 0);
        do_reset(); load(100, 0); rd_pct = 70; ack_delay = $urandom_range(0, 3); have_sp_data = 1;
        run_pkts(1, 4000); settle(1, 1, 0);
        load(512, 0);
        run_pkts(1, 4000); settle(2, 1, 0);
        do_reset(); load(1024, 0); rd_pct = 100; ack_delay = 0; have_sp_data = 1;
        wait_bytes(300, 2000); have_sp_data = 0;
        run_pkts(1, 3000); repeat (20) tick(); settle(1, 0, 512);
        have_sp_data = 1;
        wait_bytes(300, 2000);
        do_reset(); load(512, 0); have_sp_data = 1;
        run_pkts(1, 3000); settle(1, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
